// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch with one outstanding imem request.
// Holds a returned instruction while stalled and drives the IF/ID register.
module if_stage #(
    parameter int                   REG_WIDTH      = 32,
    parameter int                   REG_ADDR_WIDTH = 5,
    parameter logic [REG_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [REG_WIDTH-1:0]      branch_target,
    output logic                      imem_req,
    output logic [REG_WIDTH-1:0]      imem_addr,
    input  logic                      imem_valid,
    input  logic [31:0]               imem_rdata,
    output logic                      IF_ID_valid,
    output logic [REG_WIDTH-1:0]      IF_ID_pc,
    output logic [31:0]               IF_ID_inst,
    output logic [6:0]                IF_ID_inst_opcode,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL
    } state_t;

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]          buf_inst_q, buf_inst_d;
    logic                 kill_q, kill_d;
    logic                 if_valid_q, if_valid_d;
    logic [REG_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]          if_inst_q, if_inst_d;

    logic [REG_WIDTH-1:0] target;
    logic [REG_WIDTH-1:0] pc_next;
    logic                 req;
    logic [REG_WIDTH-1:0] addr;
    logic                 accept;
    logic [REG_WIDTH-1:0] acc_pc;
    logic [31:0]          acc_inst;

    assign target  = {branch_target[REG_WIDTH-1:2], 2'b00};
    assign pc_next = pc_q + REG_WIDTH'(4);

    // Fetch control: next state, pc, kill/buffer and the request strobe.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        req        = 1'b0;
        addr       = pc_q;
        accept     = 1'b0;
        acc_pc     = buf_pc_q;
        acc_inst   = buf_inst_q;
        unique case (state_q)
            S_REQ: begin
                req = !branch_taken;
                if (branch_taken) begin
                    pc_d = target;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!imem_valid) begin
                    if (branch_taken) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end
                end else if (kill_q) begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                    if (branch_taken) begin
                        pc_d = target;
                    end
                end else if (branch_taken) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (stall) begin
                    buf_inst_d = imem_rdata;
                    buf_pc_d   = pc_q;
                    state_d    = S_FULL;
                end else begin
                    accept   = 1'b1;
                    acc_pc   = pc_q;
                    acc_inst = imem_rdata;
                    pc_d     = pc_next;
                    req      = 1'b1;
                    addr     = pc_next;
                end
            end
            S_FULL: begin
                if (branch_taken) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    accept  = 1'b1;
                    pc_d    = pc_next;
                    req     = 1'b1;
                    addr    = pc_next;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // IF/ID next value: flush beats stall, stall holds, else load or bubble.
    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (branch_taken) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP;
        end else if (!stall) begin
            if (accept) begin
                if_valid_d = 1'b1;
                if_pc_d    = acc_pc;
                if_inst_d  = acc_inst;
            end else begin
                if_valid_d = 1'b0;
                if_inst_d  = NOP;
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign imem_req  = req && !reset;
    assign imem_addr = addr;

    assign IF_ID_valid       = if_valid_q;
    assign IF_ID_pc          = if_pc_q;
    assign IF_ID_inst        = if_inst_q;
    assign IF_ID_inst_opcode = if_inst_q[6:0];
    assign IF_ID_rd          = REG_ADDR_WIDTH'(if_inst_q[11:7]);
    assign IF_ID_rs1         = REG_ADDR_WIDTH'(if_inst_q[19:15]);
    assign IF_ID_rs2         = REG_ADDR_WIDTH'(if_inst_q[24:20]);

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random stall/branch/latency traffic against a fetch-order
// model, plus directed reset, stall, redirect and wrap-around scenarios.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        IF_ID_valid;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic [6:0]  IF_ID_inst_opcode;
    logic [4:0]  IF_ID_rd;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    logic        w_stall;
    logic        w_bt;
    logic [31:0] w_tgt;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_rdata;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_inst;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    if_stage u_dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .IF_ID_valid       (IF_ID_valid),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_inst        (IF_ID_inst),
        .IF_ID_inst_opcode (IF_ID_inst_opcode),
        .IF_ID_rd          (IF_ID_rd),
        .IF_ID_rs1         (IF_ID_rs1),
        .IF_ID_rs2         (IF_ID_rs2)
    );

    if_stage #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
        .clk               (clk),
        .reset             (reset),
        .stall             (w_stall),
        .branch_taken      (w_bt),
        .branch_target     (w_tgt),
        .imem_req          (w_req),
        .imem_addr         (w_addr),
        .imem_valid        (w_valid),
        .imem_rdata        (w_rdata),
        .IF_ID_valid       (w_if_valid),
        .IF_ID_pc          (w_if_pc),
        .IF_ID_inst        (w_if_inst),
        .IF_ID_inst_opcode (w_op),
        .IF_ID_rd          (w_rd),
        .IF_ID_rs1         (w_rs1),
        .IF_ID_rs2         (w_rs2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory side of the bench
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    logic        w_pend;

    // reference model: fetch order, outstanding/stale request, buffer
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_oaddr;
    logic        m_buf;
    logic [31:0] m_baddr;
    logic [31:0] next_fetch;
    logic        p_valid;
    logic [31:0] p_pc;
    logic [31:0] p_inst;

    // last sampled outputs for directed checks
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    logic [4:0]  s_rd;
    logic [6:0]  s_op;
    logic        s_wreq;
    logic [31:0] s_waddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        if (a == 32'h4) return 32'h00A00113;
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_oaddr    = '0;
        m_buf      = 1'b0;
        m_baddr    = '0;
        next_fetch = 32'h0;
        p_valid    = 1'b0;
        p_pc       = 32'h0;
        p_inst     = NOP;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_valid   = 1'b0;
        w_valid      = 1'b0;
        m_pend       = 1'b0;
        w_pend       = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_wreq", 32'(w_req), 32'd0);
        chk("rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_pc", IF_ID_pc, 32'h0);
        chk("rst_inst", IF_ID_inst, NOP);
        chk("rst_rd", 32'(IF_ID_rd), 32'(NOP[11:7]));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model.
    task automatic cyc(input logic st, input logic br,
                       input logic [31:0] tg, input int lat);
        logic resp, live, stale_resp, out_after, exp_req;
        stall         = st;
        branch_taken  = br;
        branch_target = tg;
        if (m_pend && m_cnt == 1) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(m_addr);
            m_pend     = 1'b0;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (m_pend) m_cnt--;
        end
        w_valid = w_pend;
        w_pend  = 1'b0;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = IF_ID_valid;
        s_pc    = IF_ID_pc;
        s_inst  = IF_ID_inst;
        s_rd    = IF_ID_rd;
        s_op    = IF_ID_inst_opcode;
        s_wreq  = w_req;
        s_waddr = w_addr;
        chk("if_valid", 32'(IF_ID_valid), 32'(p_valid));
        chk("if_pc", IF_ID_pc, p_pc);
        chk("if_inst", IF_ID_inst, p_inst);
        chk("if_op", 32'(IF_ID_inst_opcode), 32'(p_inst[6:0]));
        chk("if_rd", 32'(IF_ID_rd), 32'(p_inst[11:7]));
        chk("if_rs1", 32'(IF_ID_rs1), 32'(p_inst[19:15]));
        chk("if_rs2", 32'(IF_ID_rs2), 32'(p_inst[24:20]));
        resp       = imem_valid;
        live       = resp && m_out && !m_stale;
        stale_resp = resp && m_out && m_stale;
        out_after  = m_out && !resp;
        exp_req    = !br && !stale_resp && !out_after &&
                     !(st && (m_buf || live));
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req && imem_req) chk("imem_addr", imem_addr, next_fetch);
        if (br) begin
            p_valid = 1'b0;
            p_inst  = NOP;
        end else if (!st) begin
            if (live) begin
                p_valid = 1'b1;
                p_pc    = m_oaddr;
                p_inst  = mem_word(m_oaddr);
            end else if (m_buf) begin
                p_valid = 1'b1;
                p_pc    = m_baddr;
                p_inst  = mem_word(m_baddr);
            end else begin
                p_valid = 1'b0;
                p_inst  = NOP;
            end
        end
        if (br) begin
            m_buf = 1'b0;
        end else if (live && st) begin
            m_buf   = 1'b1;
            m_baddr = m_oaddr;
        end else if (!st) begin
            m_buf = 1'b0;
        end
        m_out = out_after;
        if (br && m_out) m_stale = 1'b1;
        if (exp_req) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_oaddr    = next_fetch;
            next_fetch = next_fetch + 32'd4;
        end
        if (br) next_fetch = {tg[31:2], 2'b00};
        if (imem_req) begin
            m_pend = 1'b1;
            m_cnt  = lat;
            m_addr = imem_addr;
        end
        w_pend = w_req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        w_stall       = 1'b0;
        w_bt          = 1'b0;
        w_tgt         = '0;
        w_valid       = 1'b0;
        w_rdata       = NOP;
        model_init();
        repeat (2) @(posedge clk);
        #1;

        // back-to-back fetch, then a 3-cycle stall over a response
        do_reset();
        cyc(0, 0, 0, 1);
        chk("A_addr0", s_addr, 32'h0);
        chk("W_addr0", s_waddr, 32'hFFFFFFFC);
        cyc(0, 0, 0, 1);
        chk("A_addr4", s_addr, 32'h4);
        chk("W_wrap", s_waddr, 32'h0);
        chk("W_req", 32'(s_wreq), 32'd1);
        cyc(0, 0, 0, 1);
        chk("A_addr8", s_addr, 32'h8);
        chk("A_pc0", s_pc, 32'h0);
        chk("A_rd1", 32'(s_rd), 32'd1);
        chk("A_op", 32'(s_op), 32'h13);
        cyc(0, 0, 0, 1);
        chk("A_pc4", s_pc, 32'h4);
        chk("A_rd2", 32'(s_rd), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1);
            chk("B_req_stall", 32'(s_req), 32'd0);
            chk("B_hold_pc", s_pc, 32'h8);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("B_buf_valid", 32'(s_valid), 32'd1);
        chk("B_buf_pc", s_pc, 32'hC);

        // redirect while a latency-3 request to 0x8 is outstanding
        do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 3);
        chk("C_addr8", s_addr, 32'h8);
        cyc(0, 1, 32'h100, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1);
            chk("C_req_wait", 32'(s_req), 32'd0);
            chk("C_bubble", 32'(s_valid), 32'd0);
        end
        cyc(0, 0, 0, 1);
        chk("C_req_tgt", 32'(s_req), 32'd1);
        chk("C_addr_tgt", s_addr, 32'h100);
        chk("C_bubble2", 32'(s_valid), 32'd0);
        cyc(0, 0, 0, 1);
        chk("C_bubble3", 32'(s_valid), 32'd0);
        cyc(1, 1, 32'h203, 1);
        chk("C_tgt_valid", 32'(s_valid), 32'd1);
        chk("C_tgt_pc", s_pc, 32'h100);
        cyc(0, 0, 0, 1);
        chk("D_flush_valid", 32'(s_valid), 32'd0);
        chk("D_flush_inst", s_inst, NOP);
        chk("E_mask_addr", s_addr, 32'h200);
        chk("E_mask_req", 32'(s_req), 32'd1);

        // random traffic with periodic reset mid-operation
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) begin
                do_reset();
            end else begin
                logic [31:0] tg;
                tg = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : $urandom;
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    tg, int'($urandom_range(1, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
